// File: rtl/vga_char_scanner.sv
// vga_char_scanner: 640x480@60 VGA raster scanner, 8x8-tile char address generator, 2-stage pixel pipeline.
// Optional macro VGA_SCAN_BORDER_EN: out-of-bounds visible pixels show P_BORDER instead of black.
`default_nettype none

module vga_char_scanner #(
  parameter int          P_H_VISIBLE = 640,
  parameter int          P_H_FRONT   = 16,
  parameter int          P_H_SYNC    = 96,
  parameter int          P_H_BACK    = 48,
  parameter int          P_V_VISIBLE = 480,
  parameter int          P_V_FRONT   = 10,
  parameter int          P_V_SYNC    = 2,
  parameter int          P_V_BACK    = 33,
  parameter int          P_SYNC_POL  = 0,
  parameter logic [11:0] P_FG        = 12'hFFF,
  parameter logic [11:0] P_BG        = 12'h000,
  parameter logic [11:0] P_BORDER    = 12'h00F
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] read_hchar,
  output logic [5:0] read_vchar,
  output logic [2:0] read_hoffset,
  output logic [2:0] read_voffset,
  input  logic       read_lit,
  input  logic       out_of_bounds,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       frame_start
);

  localparam int H_TOTAL = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(P_H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(P_V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(P_H_VISIBLE + P_H_FRONT);
  localparam logic [9:0] HS_END     = 10'(P_H_VISIBLE + P_H_FRONT + P_H_SYNC);
  localparam logic [9:0] VS_START   = 10'(P_V_VISIBLE + P_V_FRONT);
  localparam logic [9:0] VS_END     = 10'(P_V_VISIBLE + P_V_FRONT + P_V_SYNC);
  localparam logic       SYNC_ACTIVE = (P_SYNC_POL != 0);

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [11:0] OOB_COLOUR = P_BORDER;
`else
  localparam logic [11:0] OOB_COLOUR = 12'h000;
`endif

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        de0, hs0, vs0, fs0;
  logic        de1, hs1, vs1, fs1;
  logic [11:0] rgb;

  // Stage 0: free-running raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    de0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs0 = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0 = (v_cnt >= VS_START) && (v_cnt < VS_END);
    fs0 = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Address is only meaningful in the visible area; blanking reads tile (0,0) offset (0,0).
  always_comb begin
    read_hchar   = '0;
    read_vchar   = '0;
    read_hoffset = '0;
    read_voffset = '0;
    if (de0) begin
      read_hchar   = h_cnt[9:3];
      read_hoffset = h_cnt[2:0];
      read_vchar   = v_cnt[8:3];
      read_voffset = v_cnt[2:0];
    end
  end

  // Stage 1: timing delayed to line up with the buffer's one-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      fs1 <= 1'b0;
    end else begin
      de1 <= de0;
      hs1 <= hs0;
      vs1 <= vs0;
      fs1 <= fs0;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb         <= 12'h000;
      vga_hs      <= ~SYNC_ACTIVE;
      vga_vs      <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      if (!de1)
        rgb <= 12'h000;
      else if (out_of_bounds)
        rgb <= OOB_COLOUR;
      else if (read_lit)
        rgb <= P_FG;
      else
        rgb <= P_BG;
      vga_hs      <= SYNC_ACTIVE ? hs1 : ~hs1;
      vga_vs      <= SYNC_ACTIVE ? vs1 : ~vs1;
      frame_start <= fs1;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

`default_nettype wire

// File: doc/vga_char_scanner.md
# vga_char_scanner

Raster scanner and VGA output stage for the character display. It generates 640x480@60 Hz VGA timing from a free-running pixel counter and converts each visible pixel position into the 8x8-tile character read address consumed by the character buffer. It takes back the buffer's one-cycle-latency `read_lit` / `out_of_bounds` response and drives registered RGB and sync pins with pipeline-aligned timing. It sits between the character buffer and the board VGA connector.

## Interface
Parameters:
- `P_H_VISIBLE`, default 640: visible pixels per line.
- `P_H_FRONT`, default 16: horizontal front porch, in pixels.
- `P_H_SYNC`, default 96: hsync width, in pixels.
- `P_H_BACK`, default 48: horizontal back porch, in pixels.
- `P_V_VISIBLE`, default 480: visible lines.
- `P_V_FRONT`, default 10: vertical front porch, in lines.
- `P_V_SYNC`, default 2: vsync width, in lines.
- `P_V_BACK`, default 33: vertical back porch, in lines.
- `P_SYNC_POL`, default 0: active level of both syncs (0 = active-low).
- `P_FG`, default 12'hFFF: foreground colour {R,G,B} 4b each.
- `P_BG`, default 12'h000: background colour.
- `P_BORDER`, default 12'h00F: border colour (used only with macro).

Ports:
- `clk` in 1: pixel clock (25.175 MHz nominal).
- `rst` in 1: synchronous, active-high reset.
- `read_hchar` out 7: character column to buffer.
- `read_vchar` out 6: character row to buffer.
- `read_hoffset` out 3: pixel column within tile.
- `read_voffset` out 3: pixel row within tile.
- `read_lit` in 1: buffer pixel response, valid 1 cycle after address.
- `out_of_bounds` in 1: buffer coordinate-invalid flag, same timing as `read_lit`.
- `vga_r`, `vga_g`, `vga_b` out 4 each: registered colour.
- `vga_hs`, `vga_vs` out 1: registered syncs.
- `frame_start` out 1: 1-cycle pulse aligned with first visible pixel (0,0) at the pins.

## Operation
- Stage 0 (counters): `h_cnt` 10b counts 0..H_TOTAL-1 (H_TOTAL = sum of H params, 800) every cycle and wraps to 0. `v_cnt` 10b increments when `h_cnt` wraps, and wraps to 0 after V_TOTAL-1 (524).
- `de0` = (`h_cnt` < P_H_VISIBLE) & (`v_cnt` < P_V_VISIBLE).
- `hs0` active for `h_cnt` in [VIS+FRONT, VIS+FRONT+SYNC) = [656,752); `vs0` active for `v_cnt` in [490,492).
- Read address is combinational from the stage-0 counters:
  - When `de0`: `read_hchar`=`h_cnt[9:3]`, `read_hoffset`=`h_cnt[2:0]`, `read_vchar`=`v_cnt[8:3]`, `read_voffset`=`v_cnt[2:0]`.
  - When not `de0`: all address outputs are 0.
- Stage 1: `de1`, `hs1`, `vs1`, `fs1` are registered copies of stage 0. `read_lit` and `out_of_bounds` arrive this cycle.
- Stage 2 (output registers), colour select:
  - !`de1`: 0.
  - else `out_of_bounds`: per Configuration.
  - else `read_lit`: P_FG.
  - otherwise: P_BG.
- Syncs at stage 2 = `hs1`/`vs1` mapped through P_SYNC_POL.
- Counters never stall. The block has no handshake beyond the fixed 1-cycle buffer latency.

## Timing
- Latency from counter value to pins: 2 cycles, for colour, syncs and `frame_start` alike.
- `fs0` = (`h_cnt`==0 & `v_cnt`==0). `frame_start` asserts exactly when pixel (0,0) colour is at the pins.
- Reset values:
  - `h_cnt`=`v_cnt`=0.
  - Pipeline `de`/`hs`/`vs`/`fs` = inactive.
  - RGB=0.
  - `vga_hs`=`vga_vs`=!P_SYNC_POL (inactive).
  - `frame_start`=0.
  - Address outputs reflect `h_cnt`=`v_cnt`=0, i.e. all 0.
- First cycle after reset release: stage 0 is at (0,0). `frame_start` pulses 2 cycles later.
- Reset mid-frame: counters and pipeline return to reset state on the next edge. No partial sync pulse may extend past reset; syncs go inactive the cycle after `rst` is sampled.
- Line wrap at h=799: `v_cnt` increments on the same edge `h_cnt` returns to 0. At (799,524) both wrap to 0 simultaneously.
- Width rule: H_TOTAL and V_TOTAL must be ≤ 1024. VIS/8 must fit the address widths (80 ≤ 127, 60 ≤ 63).

## Configuration
- `VGA_SCAN_BORDER_EN` defined: visible pixels with `out_of_bounds`=1 output P_BORDER. This frames a buffer smaller than the screen (32x32 chars → 256x256 px region).
- Not defined: such pixels output 0 (black). `out_of_bounds` takes priority over `read_lit` in both cases.

## Test plan
- Reset: hold `rst` 3 cycles → RGB=0, `vga_hs`=`vga_vs`=1, `frame_start`=0, all address outputs 0. `frame_start`=1 exactly 2 cycles after release.
- Sync timing: run one frame → `vga_hs` low for 96 cycles, starting 658 cycles after each line's `h_cnt`=0. `vga_vs` low for 2×800 cycles, starting at line 490 (+2 cycle offset). Frame period is 420000 cycles.
- Address mapping: at `h_cnt`=333, `v_cnt`=77 → `read_hchar`=41, `read_hoffset`=5, `read_vchar`=9, `read_voffset`=5. At `h_cnt`=700 → all address outputs 0.
- Lit alignment: bench model returns `read_lit`=1 only the cycle after address (10,3,2,1) is requested → exactly one P_FG pixel appears 2 cycles after that request. All other visible pixels show P_BG.
- Out of bounds: `out_of_bounds`=1, `read_lit`=1 in visible area → RGB=P_BORDER with the macro, 0 without. Both cases give 0 during blanking.
- Mid-frame reset: assert `rst` at (400,250) for 1 cycle → next cycle counters are (0,0) and syncs are inactive. A normal frame follows with `frame_start` 2 cycles after release.
